fifo_rd_packer: RTL and testbench



---
 rtl/fifo_rd_packer.sv | 64 ++++++
 tb/tb_fifo_rd_packer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops FIFO words, packs PACK of them little-endian into one valid/ready beat, with flush of partial beats
module fifo_rd_packer #(
    parameter int DATASIZE = 8,
    parameter int PACK     = 4
) (
    input  logic                     rclk,
    input  logic                     rrst_n,
    input  logic                     rempty,
    input  logic [DATASIZE-1:0]      rdata,
    output logic                     rinc,
    output logic [DATASIZE*PACK-1:0] out_data,
    output logic [PACK-1:0]          out_keep,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     flush,
    output logic [15:0]              byte_cnt
);
    localparam int LW = $clog2(PACK + 1);
    logic [DATASIZE*(PACK-1)-1:0] acc;
    logic [DATASIZE*PACK-1:0]     acc_ext, beat;
    logic [PACK-1:0]              keep;
    logic [LW-1:0]                cnt, lanes;
    logic                         flush_pend, out_free, eff_flush, load;
    always_comb begin
        out_free  = !out_valid || out_ready;
        eff_flush = flush || flush_pend;
        rinc      = rrst_n && !rempty && !(flush_pend && !out_free) && (cnt < LW'(PACK - 1) || out_free);
        lanes     = cnt + LW'(rinc);
        load      = (rinc && cnt == LW'(PACK - 1)) || (eff_flush && out_free && lanes != '0);
        acc_ext   = {{DATASIZE{1'b0}}, acc};
    end
    // A full beat and a partial flush share one lane mux: filled lanes from acc, this cycle's pop at lane cnt, zeros above
    for (genvar i = 0; i < PACK; i++) begin : g_lane
        assign beat[i*DATASIZE +: DATASIZE] = (LW'(i) < cnt) ? acc_ext[i*DATASIZE +: DATASIZE] :
                                              (rinc && LW'(i) == cnt) ? rdata : '0;
        assign keep[i] = LW'(i) < lanes;
    end
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            acc        <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
            byte_cnt   <= '0;
            out_data   <= '0;
            out_keep   <= '0;
            out_valid  <= 1'b0;
        end else begin
            if (rinc)
                byte_cnt <= byte_cnt + 16'd1;
            for (int i = 0; i < PACK - 1; i++)
                if (rinc && cnt == LW'(i))
                    acc[i*DATASIZE +: DATASIZE] <= rdata;
            cnt        <= load ? '0 : cnt + LW'(rinc);
            flush_pend <= eff_flush && !out_free;
            if (load) begin
                out_data  <= beat;
                out_keep  <= keep;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: directed scenario tasks against a small FIFO model for fifo_rd_packer (PACK=4, DATASIZE=8)
module tb_fifo_rd_packer;
    logic        rclk = 1'b0;
    logic        rrst_n = 1'b0;
    logic        rempty;
    logic [7:0]  rdata;
    logic        rinc;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] byte_cnt;
    logic        gate = 1'b0;
    logic [7:0]  mem [2048];
    logic [10:0] rd_ptr = '0;
    logic [10:0] wr_ptr = '0;
    logic [31:0] cap_d [$];
    logic [3:0]  cap_k [$];
    logic [7:0]  ref_q [$];
    int pass_cnt = 0;
    int total_cnt = 0;

    fifo_rd_packer #(.DATASIZE(8), .PACK(4)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc),
        .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid),
        .out_ready(out_ready), .flush(flush), .byte_cnt(byte_cnt)
    );

    always #5 rclk = ~rclk;
    assign rempty = gate || (rd_ptr == wr_ptr);
    assign rdata  = mem[rd_ptr];

    always @(posedge rclk) begin
        if (rinc) rd_ptr <= rd_ptr + 11'd1;
        if (rrst_n && out_valid && out_ready) begin
            cap_d.push_back(out_data);
            cap_k.push_back(out_keep);
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 11'd1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge rclk);
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_keep !== 4'h0) $display("FAIL rst_keep got %h exp 0", out_keep); else pass_cnt++;
        total_cnt++; if (out_data !== 32'h0) $display("FAIL rst_data got %h exp 0", out_data); else pass_cnt++;
        total_cnt++; if (byte_cnt !== 16'h0) $display("FAIL rst_bytecnt got %0d exp 0", byte_cnt); else pass_cnt++;
        push(8'hA1); push(8'hA2);
        #1;
        total_cnt++; if (rinc !== 1'b0) $display("FAIL rst_rinc_held got %b exp 0", rinc); else pass_cnt++;
        rrst_n = 1'b1;
        repeat (3) @(negedge rclk);
        #1;
        total_cnt++; if (byte_cnt !== 16'd2) $display("FAIL rst_midbeat_cnt got %0d exp 2", byte_cnt); else pass_cnt++;
        push(8'h5A); push(8'h5B); push(8'h5C); push(8'h5D);
        rrst_n = 1'b0;
        #1;
        total_cnt++; if (rinc !== 1'b0) $display("FAIL rst_async_rinc got %b exp 0", rinc); else pass_cnt++;
        total_cnt++; if (byte_cnt !== 16'd0) $display("FAIL rst_async_bytecnt got %0d exp 0", byte_cnt); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0 || out_keep !== 4'h0) $display("FAIL rst_async_out got %b/%h exp 0/0", out_valid, out_keep); else pass_cnt++;
        @(negedge rclk);
        rrst_n = 1'b1;
        repeat (5) @(negedge rclk);
        #1;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL rst_restart_valid got %b exp 1", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 32'h5D5C5B5A) $display("FAIL rst_restart_lane0 got %h exp 5d5c5b5a", out_data); else pass_cnt++;
        total_cnt++; if (out_keep !== 4'hF) $display("FAIL rst_restart_keep got %h exp f", out_keep); else pass_cnt++;
        total_cnt++; if (byte_cnt !== 16'd4) $display("FAIL rst_restart_bytecnt got %0d exp 4", byte_cnt); else pass_cnt++;
        out_ready = 1'b1;
        @(negedge rclk);
    endtask

    task automatic test_streaming();
        @(negedge rclk);
        for (int i = 1; i <= 8; i++) push(8'(i));
        #1;
        total_cnt++; if (rinc !== 1'b1) $display("FAIL stream_rinc_c0 got %b exp 1", rinc); else pass_cnt++;
        for (int k = 1; k <= 9; k++) begin
            @(negedge rclk);
            #1;
            total_cnt++; if (rinc !== (k < 8)) $display("FAIL stream_rinc_c%0d got %b exp %b", k, rinc, k < 8); else pass_cnt++;
            total_cnt++; if (out_valid !== (k == 4 || k == 8)) $display("FAIL stream_valid_c%0d got %b exp %b", k, out_valid, k == 4 || k == 8); else pass_cnt++;
            if (k == 4) begin
                total_cnt++; if (out_data !== 32'h04030201 || out_keep !== 4'hF) $display("FAIL stream_beat0 got %h/%h exp 04030201/f", out_data, out_keep); else pass_cnt++;
            end
            if (k == 8) begin
                total_cnt++; if (out_data !== 32'h08070605 || out_keep !== 4'hF) $display("FAIL stream_beat1 got %h/%h exp 08070605/f", out_data, out_keep); else pass_cnt++;
            end
        end
        total_cnt++; if (byte_cnt !== 16'd12) $display("FAIL stream_bytecnt got %0d exp 12", byte_cnt); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [10:0] p0;
        int base;
        @(negedge rclk);
        out_ready = 1'b0;
        p0 = rd_ptr;
        for (int i = 0; i < 12; i++) push(8'h10 + 8'(i));
        repeat (12) @(negedge rclk);
        #1;
        total_cnt++; if (rd_ptr - p0 !== 11'd7) $display("FAIL bp_pops got %0d exp 7", rd_ptr - p0); else pass_cnt++;
        total_cnt++; if (rinc !== 1'b0) $display("FAIL bp_rinc got %b exp 0", rinc); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b1 || out_data !== 32'h13121110) $display("FAIL bp_hold got %b/%h exp 1/13121110", out_valid, out_data); else pass_cnt++;
        total_cnt++; if (byte_cnt !== 16'd19) $display("FAIL bp_bytecnt got %0d exp 19", byte_cnt); else pass_cnt++;
        base = cap_d.size();
        out_ready = 1'b1;
        repeat (12) @(negedge rclk);
        #1;
        total_cnt++; if (cap_d.size() - base !== 3) $display("FAIL bp_drain_count got %0d exp 3", cap_d.size() - base); else pass_cnt++;
        if (cap_d.size() - base >= 3) begin
            total_cnt++; if (cap_d[base] !== 32'h13121110) $display("FAIL bp_drain0 got %h exp 13121110", cap_d[base]); else pass_cnt++;
            total_cnt++; if (cap_d[base+1] !== 32'h17161514) $display("FAIL bp_drain1 got %h exp 17161514", cap_d[base+1]); else pass_cnt++;
            total_cnt++; if (cap_d[base+2] !== 32'h1B1A1918) $display("FAIL bp_drain2 got %h exp 1b1a1918", cap_d[base+2]); else pass_cnt++;
        end
        total_cnt++; if (byte_cnt !== 16'd24) $display("FAIL bp_drain_bytecnt got %0d exp 24", byte_cnt); else pass_cnt++;
    endtask

    task automatic test_flush();
        int base;
        @(negedge rclk);
        push(8'hAA); push(8'hBB); push(8'hCC);
        repeat (4) @(negedge rclk);
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_prevalid got %b exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (byte_cnt !== 16'd27) $display("FAIL flush_prebytecnt got %0d exp 27", byte_cnt); else pass_cnt++;
        flush = 1'b1;
        @(negedge rclk);
        flush = 1'b0;
        #1;
        total_cnt++; if (out_valid !== 1'b1 || out_data !== 32'h00CCBBAA || out_keep !== 4'b0111)
            $display("FAIL flush_partial got %b/%h/%b exp 1/00ccbbaa/0111", out_valid, out_data, out_keep); else pass_cnt++;
        @(negedge rclk);
        base = cap_d.size();
        flush = 1'b1;
        @(negedge rclk);
        flush = 1'b0;
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_empty_valid got %b exp 0", out_valid); else pass_cnt++;
        repeat (2) @(negedge rclk);
        total_cnt++; if (cap_d.size() !== base) $display("FAIL flush_empty_beats got %0d exp %0d", cap_d.size(), base); else pass_cnt++;
        push(8'h11);
        @(negedge rclk);
        push(8'h22);
        flush = 1'b1;
        @(negedge rclk);
        flush = 1'b0;
        #1;
        total_cnt++; if (out_valid !== 1'b1 || out_data !== 32'h00002211 || out_keep !== 4'b0011)
            $display("FAIL flush_with_pop got %b/%h/%b exp 1/00002211/0011", out_valid, out_data, out_keep); else pass_cnt++;
        total_cnt++; if (byte_cnt !== 16'd29) $display("FAIL flush_bytecnt got %0d exp 29", byte_cnt); else pass_cnt++;
    endtask

    task automatic test_flush_backpressure();
        int base;
        @(negedge rclk);
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'h30 + 8'(i));
        repeat (8) @(negedge rclk);
        #1;
        total_cnt++; if (out_data !== 32'h33323130 || byte_cnt !== 16'd35) $display("FAIL fbp_setup got %h/%0d exp 33323130/35", out_data, byte_cnt); else pass_cnt++;
        flush = 1'b1;
        @(negedge rclk);
        flush = 1'b0;
        push(8'h36); push(8'h37);
        #1;
        total_cnt++; if (rinc !== 1'b0) $display("FAIL fbp_rinc_forced got %b exp 0", rinc); else pass_cnt++;
        repeat (3) @(negedge rclk);
        #1;
        total_cnt++; if (rinc !== 1'b0) $display("FAIL fbp_rinc_still got %b exp 0", rinc); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b1 || out_data !== 32'h33323130 || byte_cnt !== 16'd35)
            $display("FAIL fbp_hold got %b/%h/%0d exp 1/33323130/35", out_valid, out_data, byte_cnt); else pass_cnt++;
        base = cap_d.size();
        out_ready = 1'b1;
        @(negedge rclk);
        #1;
        total_cnt++; if (out_valid !== 1'b1 || out_data !== 32'h00363534 || out_keep !== 4'b0111)
            $display("FAIL fbp_partial got %b/%h/%b exp 1/00363534/0111", out_valid, out_data, out_keep); else pass_cnt++;
        total_cnt++; if (cap_d.size() - base !== 1 || cap_d[base] !== 32'h33323130)
            $display("FAIL fbp_old_accept got %0d beats exp 1 of 33323130", cap_d.size() - base); else pass_cnt++;
        flush = 1'b1;
        @(negedge rclk);
        flush = 1'b0;
        #1;
        total_cnt++; if (out_valid !== 1'b1 || out_data !== 32'h00000037 || out_keep !== 4'b0001)
            $display("FAIL fbp_tail got %b/%h/%b exp 1/00000037/0001", out_valid, out_data, out_keep); else pass_cnt++;
        total_cnt++; if (byte_cnt !== 16'd37) $display("FAIL fbp_bytecnt got %0d exp 37", byte_cnt); else pass_cnt++;
        @(negedge rclk);
    endtask

    task automatic test_sparse();
        int base, viol, mism, cycles;
        logic [31:0] expv;
        viol = 0; mism = 0; cycles = 0;
        @(negedge rclk);
        rrst_n = 1'b0;
        #1;
        rrst_n = 1'b1;
        base = cap_d.size();
        for (int i = 0; i < 1000; i++) begin
            ref_q.push_back(8'($urandom));
            push(ref_q[i]);
        end
        while (rd_ptr != wr_ptr && cycles < 8000) begin
            @(negedge rclk);
            gate = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            cycles++;
            #1;
            if (rinc && rempty) viol++;
        end
        @(negedge rclk);
        gate = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge rclk);
        #1;
        total_cnt++; if (rd_ptr !== wr_ptr) $display("FAIL sparse_timeout got %0d left exp 0", wr_ptr - rd_ptr); else pass_cnt++;
        total_cnt++; if (viol !== 0) $display("FAIL sparse_rinc_when_empty got %0d exp 0", viol); else pass_cnt++;
        total_cnt++; if (cap_d.size() - base !== 250) $display("FAIL sparse_beats got %0d exp 250", cap_d.size() - base); else pass_cnt++;
        for (int b = 0; b < 250 && base + b < cap_d.size(); b++) begin
            expv = {ref_q[4*b+3], ref_q[4*b+2], ref_q[4*b+1], ref_q[4*b]};
            if (cap_d[base+b] !== expv || cap_k[base+b] !== 4'hF) mism++;
        end
        total_cnt++; if (mism !== 0) $display("FAIL sparse_data got %0d bad beats exp 0", mism); else pass_cnt++;
        total_cnt++; if (byte_cnt !== 16'd1000) $display("FAIL sparse_bytecnt got %0d exp 1000", byte_cnt); else pass_cnt++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_flush_backpressure();
        test_sparse();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
